stage2_pipe: RTL and testbench
==============================

Name: stage2_pipe

Overview:
- Registered front stage of the 8-bit conditional-sum adder; sits directly upstream of stage3.
- Accepts full 8-bit operands and carry-in, computes the low-nibble sum and carry with the same 2-bit conditional-sum structure, and forwards the upper nibbles.
- Its outputs drive stage3 as A, B, Cin and Sin.
- Decouples producer and consumer with a valid/ready handshake and a 2-entry skid buffer, sustaining one operation per cycle under backpressure.

Parameters:
- HW, 4, half-operand width; the block supports only HW=4, fixed by stage3's port widths.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  producer offers an operation
- in_ready  output  1  block can accept this cycle
- in_a  input  8  operand A
- in_b  input  8  operand B
- in_cin  input  1  adder carry-in
- out_valid  output  1  output entry valid
- out_ready  input  1  consumer accepts this cycle
- out_a  output  4  in_a[7:4] of the head entry (stage3 A)
- out_b  output  4  in_b[7:4] of the head entry (stage3 B)
- out_cin  output  1  carry out of the low nibble (stage3 Cin)
- out_sin  output  4  low-nibble sum (stage3 Sin)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Low-nibble arithmetic (combinational, before the entry register):
  - Two 2-bit slices each compute sum/carry for carry-in 0 and carry-in 1.
  - Low slice result is selected by in_cin.
  - High slice result is selected by the low slice's selected carry.
  - Required result: {out_cin, out_sin} == in_a[3:0] + in_b[3:0] + in_cin, exact, 5-bit, no truncation.
- Each entry stores {a_hi[3:0], b_hi[3:0], cout, sum[3:0]} = 13 bits.
- Transfers:
  - Push = in_valid & in_ready.
  - Pop = out_valid & out_ready.
  - Entries leave in arrival order; no reordering, duplication or loss.
- State machine (main register + skid register):
  - EMPTY: out_valid=0, in_ready=1. Push -> main loaded, go ONE.
  - ONE: out_valid=1, in_ready=1.
    - Push & pop: main reloaded with new entry, stay ONE.
    - Push only: new entry to skid, go FULL.
    - Pop only: go EMPTY.
    - Neither: hold.
  - FULL: out_valid=1, in_ready=0; push impossible. Pop: skid moves to main, go ONE.
- Outputs are registered: out_* always present the main register.
- Latency: 1 cycle from push to out_valid when EMPTY, or when ONE with a simultaneous pop.
- Throughput: 1 operation per cycle while out_ready=1.
- in_ready is a registered function of state only, with no combinational path from out_ready.
- Stability: while out_valid=1 and out_ready=0, all out_* hold unchanged.
- Data changes on in_a/in_b/in_cin when no push occurs have no effect.
- Reset:
  - Any cycle with reset=1 forces state EMPTY at the next edge and zeroes both registers, so out_a, out_b, out_sin = 0 and out_cin=0.
  - out_valid=0 during reset.
  - in_ready=0 while reset=1 and for the cycle at which reset is sampled; it returns to 1 the cycle after reset deasserts.
  - Reset mid-operation discards all held entries; no push is accepted in a reset cycle.
- in_valid while in_ready=0: ignored. The producer holds data until accepted; the block does not check this.
- No X propagation: registers are defined from the first reset onward.

Test Plan:
- Basic add: push a=8'h3C, b=8'h5A, cin=0, out_ready=1 -> next cycle out_valid=1, out_a=4'h3, out_b=4'h5, out_sin=4'h6, out_cin=1; through stage3 the sum is 8'h96.
- Carry propagation: push a=8'hFF, b=8'h01, cin=0 -> out_sin=0, out_cin=1, out_a=F, out_b=0. Push a=8'h0F, b=8'h00, cin=1 -> out_sin=0, out_cin=1.
- Backpressure: out_ready=0; push ops X1 (a=01, b=01) then X2 (a=02, b=02) in consecutive cycles, and hold X3 offered.
  - Required: in_ready drops after X2 is accepted.
  - Required: out_* hold X1 (out_sin=2) for all stalled cycles.
  - Release out_ready=1 -> X1, X2, X3 emerge in order on consecutive pops (out_sin=2, 4, 6).
- Streaming: 32 random operand/cin pushes back to back with out_ready=1 -> one output per cycle, 1-cycle latency, each matching the reference sum bit-exactly.
- Random stall: random in_valid/out_ready over 1000 cycles -> scoreboard shows no loss, duplication or reordering; in_ready never depends combinationally on out_ready.
- Reset mid-FULL: fill both entries, assert reset one cycle -> next cycle out_valid=0, all out_*=0, in_ready=0; the following cycle in_ready=1 and the old entries never appear.

Source files
------------

// File: rtl/stage2_pipe.sv
// Registered low-nibble conditional-sum stage feeding stage3. A 2-entry skid
// buffer (main + skid) decouples the valid/ready handshakes on either side.
module stage2_pipe #(
    parameter int HW = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*HW-1:0] in_a,
    input  logic [2*HW-1:0] in_b,
    input  logic            in_cin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [HW-1:0]   out_a,
    output logic [HW-1:0]   out_b,
    output logic            out_cin,
    output logic [HW-1:0]   out_sin
);

    typedef struct packed {
        logic [HW-1:0] a_hi;
        logic [HW-1:0] b_hi;
        logic          cout;
        logic [HW-1:0] sum;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state;
    entry_t main_q, skid_q, entry_in;
    logic   rdy_q;
    logic   push, pop;
    logic [2:0] lo0, lo1, hi0, hi1, lo_sel, hi_sel;

    // Each 2-bit slice precomputes both carry-in cases; the carry then just muxes.
    always_comb begin
        lo0    = {1'b0, in_a[1:0]} + {1'b0, in_b[1:0]};
        lo1    = {1'b0, in_a[1:0]} + {1'b0, in_b[1:0]} + 3'd1;
        hi0    = {1'b0, in_a[3:2]} + {1'b0, in_b[3:2]};
        hi1    = {1'b0, in_a[3:2]} + {1'b0, in_b[3:2]} + 3'd1;
        lo_sel = in_cin ? lo1 : lo0;
        hi_sel = lo_sel[2] ? hi1 : hi0;
        entry_in.a_hi = in_a[2*HW-1:HW];
        entry_in.b_hi = in_b[2*HW-1:HW];
        entry_in.cout = hi_sel[2];
        entry_in.sum  = {hi_sel[1:0], lo_sel[1:0]};
    end

    assign in_ready  = rdy_q;
    assign out_valid = (state != EMPTY);
    assign push      = in_valid & rdy_q;
    assign pop       = out_valid & out_ready;

    assign out_a   = main_q.a_hi;
    assign out_b   = main_q.b_hi;
    assign out_cin = main_q.cout;
    assign out_sin = main_q.sum;

    // rdy_q is the registered "next state is not FULL", so out_ready never
    // reaches in_ready combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
            rdy_q  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    rdy_q <= 1'b1;
                    if (push) begin
                        main_q <= entry_in;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    rdy_q <= 1'b1;
                    if (push && pop) begin
                        main_q <= entry_in;
                    end else if (push) begin
                        skid_q <= entry_in;
                        state  <= FULL;
                        rdy_q  <= 1'b0;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    rdy_q <= 1'b0;
                    if (pop) begin
                        main_q <= skid_q;
                        state  <= ONE;
                        rdy_q  <= 1'b1;
                    end
                end
                default: begin
                    state <= EMPTY;
                    rdy_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage2_pipe.sv
// Bench for stage2_pipe: vector table, backpressure, streaming, random stall
// scoreboard and reset while full.
module tb_stage2_pipe;

    logic       clk = 1'b0;
    logic       reset, in_valid, in_ready, in_cin, out_valid, out_ready, out_cin;
    logic [7:0] in_a, in_b;
    logic [3:0] out_a, out_b, out_sin;

    int checks = 0;
    int errors = 0;

    stage2_pipe #(.HW(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_cin(out_cin), .out_sin(out_sin)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a, b;
        logic       cin;
        logic [3:0] ea, eb;
        logic       ec;
        logic [3:0] es;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] model(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [4:0] s;
        s = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, c};
        return {a[7:4], b[7:4], s};
    endfunction

    function automatic logic [12:0] cur_out();
        return {out_a, out_b, out_cin, out_sin};
    endfunction

    logic [7:0]  sa[32], sb[32];
    logic        sc[32];
    logic [12:0] q[$];
    logic [12:0] prev_out, cur, exp_e;
    bit          held, prev_stall;
    logic        r;

    initial begin
        vecs[0] = '{8'h3C, 8'h5A, 1'b0, 4'h3, 4'h5, 1'b1, 4'h6};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 4'hF, 4'h0, 1'b1, 4'h0};
        vecs[2] = '{8'h0F, 8'h00, 1'b1, 4'h0, 4'h0, 1'b1, 4'h0};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0};
        vecs[4] = '{8'h12, 8'h34, 1'b1, 4'h1, 4'h3, 1'b0, 4'h7};
        vecs[5] = '{8'hA7, 8'hB8, 1'b0, 4'hA, 4'hB, 1'b0, 4'hF};
        vecs[6] = '{8'h5E, 8'hC9, 1'b1, 4'h5, 4'hC, 1'b1, 4'h8};
        vecs[7] = '{8'h8F, 8'h7F, 1'b1, 4'h8, 4'h7, 1'b1, 4'hF};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0;

        // Reset state and in_ready recovery
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_data", 32'(cur_out()), 32'd0);
        step;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready_sampled", 32'(in_ready), 32'd0);
        step;
        @(negedge clk);
        chk("rst_ready_back", 32'(in_ready), 32'd1);
        chk("rst_valid_back", 32'(out_valid), 32'd0);
        step;

        // Vector table, one op at a time with 1-cycle latency
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_a = vecs[i].a; in_b = vecs[i].b; in_cin = vecs[i].cin;
            out_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'd1);
            step;
            in_valid = 1'b0;
            in_a = 8'hAA; in_b = 8'h55; in_cin = 1'b1;
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_out", i), 32'(cur_out()),
                32'({vecs[i].ea, vecs[i].eb, vecs[i].ec, vecs[i].es}));
            step;
        end
        @(negedge clk);
        chk("vec_drained", 32'(out_valid), 32'd0);
        step;

        // Backpressure: X1, X2 fill both entries, X3 waits
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'h01; in_b = 8'h01; in_cin = 1'b0;
        step;
        in_a = 8'h02; in_b = 8'h02;
        step;
        in_a = 8'h03; in_b = 8'h03;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp_ready_low%0d", k), 32'(in_ready), 32'd0);
            chk($sformatf("bp_hold%0d", k), 32'(cur_out()), 32'(model(8'h01, 8'h01, 1'b0)));
            step;
        end
        out_ready = 1'b1;
        step;
        @(negedge clk);
        chk("bp_pop_x2", 32'(cur_out()), 32'(model(8'h02, 8'h02, 1'b0)));
        chk("bp_sin_x2", 32'(out_sin), 32'h4);
        step;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_pop_x3", 32'(cur_out()), 32'(model(8'h03, 8'h03, 1'b0)));
        chk("bp_sin_x3", 32'(out_sin), 32'h6);
        chk("bp_valid_x3", 32'(out_valid), 32'd1);
        step;
        @(negedge clk);
        chk("bp_empty", 32'(out_valid), 32'd0);
        step;

        // Streaming: back-to-back random ops, one result per cycle
        for (int k = 0; k < 32; k++) begin
            sa[k] = 8'($urandom); sb[k] = 8'($urandom); sc[k] = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            if (k < 32) begin
                in_valid = 1'b1; in_a = sa[k]; in_b = sb[k]; in_cin = sc[k];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (k > 0) begin
                chk($sformatf("stream%0d_valid", k - 1), 32'(out_valid), 32'd1);
                chk($sformatf("stream%0d_out", k - 1), 32'(cur_out()),
                    32'(model(sa[k-1], sb[k-1], sc[k-1])));
            end
            chk($sformatf("stream%0d_ready", k), 32'(in_ready), 32'd1);
            step;
        end
        @(negedge clk);
        chk("stream_empty", 32'(out_valid), 32'd0);
        step;

        // Random in_valid / out_ready with scoreboard
        held = 1'b0; prev_stall = 1'b0; prev_out = '0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (!held) begin
                in_valid = 1'($urandom_range(0, 1));
                in_a = 8'($urandom); in_b = 8'($urandom); in_cin = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            cur = cur_out();
            if (prev_stall) chk("rnd_stall_hold", 32'(cur), 32'(prev_out));
            chk("rnd_valid_occ", 32'(out_valid), 32'(q.size() != 0));
            r = in_ready;
            out_ready = ~out_ready;
            #1;
            chk("rnd_ready_indep", 32'(in_ready), 32'(r));
            out_ready = ~out_ready;
            #1;
            if (out_valid && out_ready && q.size() != 0) begin
                exp_e = q.pop_front();
                chk("rnd_order", 32'(cur), 32'(exp_e));
            end
            if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_cin));
            held = in_valid && !in_ready;
            prev_stall = out_valid && !out_ready;
            prev_out = cur;
            step;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int d = 0; d < 6; d++) begin
            @(negedge clk);
            if (out_valid) begin
                if (q.size() != 0) begin
                    exp_e = q.pop_front();
                    chk("drain_order", 32'(cur_out()), 32'(exp_e));
                end else begin
                    chk("drain_extra", 32'(out_valid), 32'd0);
                end
            end
            step;
        end
        chk("drain_left", 32'(q.size()), 32'd0);
        @(negedge clk);
        chk("drain_valid", 32'(out_valid), 32'd0);
        step;

        // Reset while FULL discards both entries
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22; in_cin = 1'b0;
        step;
        in_a = 8'h33; in_b = 8'h44;
        step;
        in_a = 8'h55; in_b = 8'h55;
        @(negedge clk);
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        step;
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd0);
        chk("midrst_data", 32'(cur_out()), 32'd0);
        step;
        @(negedge clk);
        chk("midrst_ready_back", 32'(in_ready), 32'd1);
        chk("midrst_still_empty", 32'(out_valid), 32'd0);
        step;
        in_valid = 1'b1; in_a = 8'h66; in_b = 8'h11; in_cin = 1'b0; out_ready = 1'b1;
        step;
        in_valid = 1'b0;
        @(negedge clk);
        chk("postrst_valid", 32'(out_valid), 32'd1);
        chk("postrst_out", 32'(cur_out()), 32'({4'h6, 4'h1, 1'b0, 4'h7}));
        step;
        @(negedge clk);
        chk("postrst_no_old", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
